// File: rtl/mm_copy_master.sv
// Avalon-MM copy engine: reads `length` words from src_addr and writes them, in order, to dst_addr.
// Define MM_COPY_WRITE_RESP_EN to track write responses before signalling completion.
module mm_copy_master #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic [1:0]  avm_response,
    input  logic        avm_writeresponsevalid
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t        state;
    logic [31:0]   rd_addr;
    logic [31:0]   wr_addr;
    logic [15:0]   reads_left;
    logic [15:0]   writes_left;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   mem [FIFO_DEPTH];

    logic          in_run;
    logic          rd_acc;
    logic          wr_acc;
    logic          cmd_free;
    logic          rvalid;
    logic          push;
    logic          rd_err;
    logic          wr_err;
    logic          err_next;
    logic          issue_write;
    logic          issue_read;
    logic [CW-1:0] fifo_after_pop;
    logic [CW-1:0] fifo_next;
    logic [CW-1:0] outst_next;
    logic [7:0]    credit;
    logic [31:0]   head_data;

    // Command handshake: avm_read/avm_write offer a command that transfers in any cycle with
    // avm_waitrequest=0; until then address, command and data are held unchanged.
    always_comb begin
        in_run         = (state == RUN);
        rd_acc         = avm_read && !avm_waitrequest;
        wr_acc         = avm_write && !avm_waitrequest;
        cmd_free       = !(avm_read || avm_write) || !avm_waitrequest;
        rvalid         = in_run && avm_readdatavalid;
        push           = rvalid && (avm_response == 2'b00) && !error;
        rd_err         = rvalid && (avm_response != 2'b00);
        fifo_after_pop = fifo_count - CW'(wr_acc);
        fifo_next      = fifo_after_pop + CW'(push);
        outst_next     = outstanding + CW'(rd_acc) - CW'(rvalid);
        credit         = 8'(fifo_next) + 8'(outst_next);
        err_next       = error || rd_err || wr_err;
        issue_write    = in_run && cmd_free && (fifo_next != '0);
        issue_read     = in_run && cmd_free && !issue_write && (reads_left != 16'd0) &&
                         !err_next && (credit < 8'(FIFO_DEPTH));
        // Bypass the FIFO when it is about to be empty so returning data is written one cycle later.
        head_data      = (fifo_after_pop != '0) ? mem[rd_ptr + AW'(wr_acc)] : avm_readdata;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= avm_readdata;
    end

`ifdef MM_COPY_WRITE_RESP_EN
    logic [16:0] wresp_count;
    logic        wresp_dec;

    assign wresp_dec = busy && avm_writeresponsevalid && (wresp_count != 17'd0);
    assign wr_err    = wresp_dec && (avm_response != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wresp_count <= '0;
        end else begin
            wresp_count <= wresp_count + 17'(wr_acc) - 17'(wresp_dec);
        end
    end
`else
    logic unused_wresp;

    assign unused_wresp = avm_writeresponsevalid;
    assign wr_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            rd_addr        <= '0;
            wr_addr        <= '0;
            reads_left     <= '0;
            writes_left    <= '0;
            fifo_count     <= '0;
            outstanding    <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
        end else begin
            done        <= 1'b0;
            fifo_count  <= fifo_next;
            outstanding <= outst_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (wr_acc) begin
                rd_ptr      <= rd_ptr + AW'(1);
                writes_left <= writes_left - 16'd1;
            end
            if (rd_err || wr_err) error <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr     <= src_addr & 32'hFFFF_FFFC;
                        wr_addr     <= dst_addr & 32'hFFFF_FFFC;
                        reads_left  <= length;
                        writes_left <= length;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (length == 16'd0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (issue_write) begin
                        avm_write      <= 1'b1;
                        avm_read       <= 1'b0;
                        avm_address    <= wr_addr;
                        avm_writedata  <= head_data;
                        avm_byteenable <= 4'hF;
                        wr_addr        <= wr_addr + 32'd4;
                    end else if (issue_read) begin
                        avm_read       <= 1'b1;
                        avm_write      <= 1'b0;
                        avm_address    <= rd_addr;
                        avm_byteenable <= 4'hF;
                        rd_addr        <= rd_addr + 32'd4;
                        reads_left     <= reads_left - 16'd1;
                    end else if (cmd_free) begin
                        avm_read       <= 1'b0;
                        avm_write      <= 1'b0;
                        avm_byteenable <= 4'h0;
                    end
                    // An errored copy ends once every queued word is written and all reads have returned.
                    if ((writes_left == 16'd0) ||
                        (error && (fifo_count == '0) && (outstanding == '0) && !avm_read && !avm_write)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
`ifdef MM_COPY_WRITE_RESP_EN
                    if (wresp_count == 17'd0) state <= FINISH;
`else
                    state <= FINISH;
`endif
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_copy_master.sv
// Self-checking bench for mm_copy_master: Avalon slave model with configurable latency, stalls and error injection.
`timescale 1ns/1ps
module tb_mm_copy_master;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [1:0]  avm_response;
    logic        avm_writeresponsevalid;

    mm_copy_master #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .src_addr               (src_addr),
        .dst_addr               (dst_addr),
        .length                 (length),
        .busy                   (busy),
        .done                   (done),
        .error                  (error),
        .avm_address            (avm_address),
        .avm_read               (avm_read),
        .avm_write              (avm_write),
        .avm_byteenable         (avm_byteenable),
        .avm_writedata          (avm_writedata),
        .avm_waitrequest        (avm_waitrequest),
        .avm_readdata           (avm_readdata),
        .avm_readdatavalid      (avm_readdatavalid),
        .avm_response           (avm_response),
        .avm_writeresponsevalid (avm_writeresponsevalid)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_rsp_t;

    rd_rsp_t     rpend[$];
    int          wpend[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_rd_q[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat = 2;
    int          err_idx = -1;
    int          wait_pct = 0;
    int          wresp_delay = 0;
    logic [31:0] salt = 32'h0;
    int          ra = 0, wa = 0, rv = 0, pushes = 0, rd_idx = 0, level = 0;
    int          done_cnt = 0, done_cyc = 0, start_cyc = 0, cmd_cnt = 0;
    int          first_rv_cyc = -1, first_wr_cyc = -1, last_wr_cyc = -1, last_wresp_cyc = -1;
    bit          err_seen = 0;
    bit          prev_stall = 0;
    logic [33:0] prev_cmd = '0;
    logic [31:0] prev_wdata = '0;
    rd_rsp_t     drv_rsp;
    rd_rsp_t     mon_rsp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Slave driver: updates bus inputs just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        avm_readdatavalid      = 1'b0;
        avm_writeresponsevalid = 1'b0;
        avm_response           = 2'b00;
        avm_readdata           = $urandom;
        avm_waitrequest        = (wait_pct > 0) && ($urandom_range(0, 99) < wait_pct);
        if (rst_n) begin
            if (rpend.size() > 0 && rpend[0].due <= cyc) begin
                drv_rsp           = rpend.pop_front();
                avm_readdatavalid = 1'b1;
                avm_readdata      = drv_rsp.data;
                avm_response      = drv_rsp.resp;
                if (first_rv_cyc < 0) first_rv_cyc = cyc;
                rv++;
                if (drv_rsp.resp != 2'b00) err_seen = 1'b1;
                else if (!err_seen) pushes++;
            end else if (wpend.size() > 0 && wpend[0] <= cyc) begin
                void'(wpend.pop_front());
                avm_writeresponsevalid = 1'b1;
                last_wresp_cyc         = cyc;
            end
        end
    end

    // Monitor and scoreboard: samples DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_cmd", {30'd0, avm_read, avm_write, avm_address}, {30'd0, prev_cmd});
                if (prev_cmd[32]) check("stall_wdata", avm_writedata, prev_wdata);
            end
            prev_stall = (avm_read || avm_write) && avm_waitrequest;
            prev_cmd   = {avm_read, avm_write, avm_address};
            prev_wdata = avm_writedata;
            if (avm_read || avm_write) begin
                cmd_cnt++;
                check("byteen_cmd", avm_byteenable, 4'hF);
                check("one_cmd", avm_read && avm_write, 1'b0);
            end else begin
                check("byteen_idle", avm_byteenable, 4'h0);
            end
            if (avm_write && first_wr_cyc < 0) first_wr_cyc = cyc;
            if (avm_read && !avm_waitrequest) begin
                ra++;
                if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
                else check("rd_addr", avm_address, exp_rd_q.pop_front());
                mon_rsp.due  = cyc + lat;
                mon_rsp.data = mem_word(avm_address);
                mon_rsp.resp = (rd_idx == err_idx) ? 2'b10 : 2'b00;
                rpend.push_back(mon_rsp);
                rd_idx++;
            end
            if (avm_write && !avm_waitrequest) begin
                wa++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) check("wr_extra", 1, 0);
                else check("wr_addr_data", {avm_address, avm_writedata}, exp_q.pop_front());
                if (wresp_delay > 0) wpend.push_back(cyc + wresp_delay);
            end
            level = (ra - rv) + (pushes - wa);
            if (busy) check("credit", level <= DEPTH, 1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] s;
        logic [31:0] d;
        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        exp_q.delete();
        exp_rd_q.delete();
        rpend.delete();
        wpend.delete();
        ra = 0; wa = 0; rv = 0; pushes = 0; rd_idx = 0;
        err_seen = 1'b0; done_cnt = 0; cmd_cnt = 0;
        first_rv_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; last_wresp_cyc = -1;
        for (int i = 0; i < len; i++) begin
            exp_rd_q.push_back(s + 32'(4 * i));
            if (err_idx < 0 || i < err_idx) exp_q.push_back({d + 32'(4 * i), mem_word(s + 32'(4 * i))});
        end
        @(posedge clk);
        #2;
        src_addr  = src;
        dst_addr  = dst;
        length    = 16'(len);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("start_clears_err", error, 1'b0);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_copy(input bit exp_err);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("idle_busy", busy, 1'b0);
        check("err_flag", error, exp_err);
        check("writes_all", exp_q.size(), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        avm_waitrequest        = 1'b0;
        avm_readdata           = '0;
        avm_readdatavalid      = 1'b0;
        avm_response           = 2'b00;
        avm_writeresponsevalid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", {busy, done, error}, 3'b000);
        check("rst_cmd", {avm_read, avm_write, avm_byteenable}, 6'd0);
        check("rst_addr", avm_address, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic copy with 2-cycle read latency
        salt = 32'h1111_0000; lat = 2;
        start_copy(32'h1000, 32'h2000, 4);
        finish_copy(1'b0);
        check("rv_to_write_lat", first_wr_cyc - first_rv_cyc, 1);
        check("drain_one_cycle", done_cyc - last_wr_cyc, 4);
        check("write_count4", wa, 4);

        // Long copy against slow memory, with an ignored start mid-copy
        salt = 32'h2222_0000; lat = 10;
        start_copy(32'h8000, 32'h9000, 20);
        repeat (5) @(posedge clk);
        #2;
        src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; length = 16'd3; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        finish_copy(1'b0);
        check("write_count20", wa, 20);

        // Random stalls, unaligned random addresses
        salt = $urandom; lat = 3; wait_pct = 50;
        start_copy($urandom, $urandom, 12);
        finish_copy(1'b0);
        wait_pct = 0;

        // Address wrap past 2^32
        salt = 32'h3333_0000; lat = 1;
        start_copy(32'hFFFF_FFF6, 32'hFFFF_FFF9, 4);
        finish_copy(1'b0);

        // Error on third read
        salt = 32'h4444_0000; lat = 2; err_idx = 2;
        start_copy(32'h5000, 32'h6000, 6);
        finish_copy(1'b1);
        check("err_write_count", wa, 2);
        err_idx = -1;
        start_copy(32'h5100, 32'h6100, 2);
        finish_copy(1'b0);

        // Zero-length copy
        start_copy(32'h10, 32'h20, 0);
        finish_copy(1'b0);
        check("len0_done_lat", done_cyc - start_cyc, 2);
        check("len0_no_cmd", cmd_cnt, 0);

        // Reset mid-copy, then a clean copy
        salt = 32'h5555_0000; lat = 4;
        start_copy(32'h3000, 32'h4000, 10);
        repeat (8) @(posedge clk);
        #3;
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_status", {busy, done, error}, 3'b000);
        check("mid_rst_cmd", {avm_read, avm_write, avm_byteenable}, 6'd0);
        check("mid_rst_addr", avm_address, 32'd0);
        check("mid_rst_wdata", avm_writedata, 32'd0);
        prev_stall = 1'b0;
        rpend.delete();
        wpend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        salt = 32'h6666_0000;
        start_copy(32'h3100, 32'h4100, 3);
        finish_copy(1'b0);
        check("post_rst_writes", wa, 3);

`ifdef MM_COPY_WRITE_RESP_EN
        // Completion must wait for delayed write responses
        salt = 32'h7777_0000; lat = 2; wresp_delay = 5;
        start_copy(32'h7000, 32'h7400, 5);
        finish_copy(1'b0);
        check("done_after_wresp", done_cyc > last_wresp_cyc, 1'b1);
        check("wresp_all", wpend.size(), 0);
        wresp_delay = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
